// File: rtl/llc_access_ctrl.sv
// rtl/llc_access_ctrl.sv - LLC tag/MESI/tree-PLRU sequencing controller
// Purpose: holds one set-associative tag/MESI/PLRU array in flops, serves one CPU or snoop
//   request at a time, picks victims, writes back dirty lines and fills over a bus port.
// Ports:
//   clk, rst_n                         clock (rising edge), asynchronous active-low reset
//   req_valid/ready/op/addr            request handshake (0 READ, 1 WRITE, 2 SNOOP_INV, 3 CLEAR)
//   rsp_valid/hit/way/mesi             one-cycle completion pulse and result
//   bus_req_valid/ready/op/addr        bus request (0 READ, 1 RWITM, 2 INVAL, 3 WRITEBACK)
//   bus_rsp_valid/shared               fill return for READ/RWITM
//   read_cnt/write_cnt/hit_cnt/miss_cnt saturating statistics
module llc_access_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int OFFSET_BITS  = 6,
   parameter int NUM_SETS     = 16,
   parameter int NUM_WAYS     = 16,
   parameter int COUNTER_BITS = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [1:0]                    req_op,
   input  logic [ADDR_W-1:0]             req_addr,
   output logic                          rsp_valid,
   output logic                          rsp_hit,
   output logic [$clog2(NUM_WAYS)-1:0]   rsp_way,
   output logic [1:0]                    rsp_mesi,
   output logic                          bus_req_valid,
   input  logic                          bus_req_ready,
   output logic [1:0]                    bus_req_op,
   output logic [ADDR_W-1:0]             bus_req_addr,
   input  logic                          bus_rsp_valid,
   input  logic                          bus_rsp_shared,
   output logic [COUNTER_BITS-1:0]       read_cnt,
   output logic [COUNTER_BITS-1:0]       write_cnt,
   output logic [COUNTER_BITS-1:0]       hit_cnt,
   output logic [COUNTER_BITS-1:0]       miss_cnt
);
   localparam int SET_BITS  = $clog2(NUM_SETS);
   localparam int WAY_BITS  = $clog2(NUM_WAYS);
   localparam int TAG_W     = ADDR_W - SET_BITS - OFFSET_BITS;
   localparam int PLRU_BITS = NUM_WAYS - 1;

   localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
   localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_SNOOP = 2'd2, OP_CLEAR = 2'd3;
   localparam logic [1:0] BUS_READ = 2'd0, BUS_RWITM = 2'd1, BUS_INVAL = 2'd2, BUS_WB = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_INV, S_WB, S_FILL, S_RESP} state_t;

   state_t                  state, next_state;
   logic [1:0]              op_r;
   logic [TAG_W-1:0]        tag_r, wb_tag_r;
   logic [SET_BITS-1:0]     set_r;
   logic [WAY_BITS-1:0]     way_r;
   logic                    hit_r, fill_issued;
   logic [1:0]              mesi_r;

   logic [TAG_W-1:0]        tag_q  [NUM_SETS][NUM_WAYS];
   logic [1:0]              mesi_q [NUM_SETS][NUM_WAYS];
   logic [PLRU_BITS-1:0]    plru_q [NUM_SETS];

   logic                    hit, has_inv;
   logic [WAY_BITS-1:0]     hit_way, inv_way, victim;
   logic [1:0]              hit_state, vic_state;

   logic unused_offset;
   assign unused_offset = &{1'b0, req_addr[OFFSET_BITS-1:0]};

   // Follow the tree from the root: bit 0 walks left (2n+1), bit 1 walks right (2n+2).
   function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] p);
      logic [WAY_BITS-1:0] node, w;
      logic                b;
      node = '0;
      w    = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         b    = p[node];
         w    = WAY_BITS'({w, b});
         node = WAY_BITS'(2 * int'(node) + 1 + int'(b));
      end
      return w;
   endfunction

   // Every node on the accessed way's path is turned to point at the other subtree.
   function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] p,
                                                       input logic [WAY_BITS-1:0] w);
      logic [WAY_BITS-1:0] node;
      logic                b;
      node = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         b       = w[WAY_BITS-1-l];
         p[node] = ~b;
         node    = WAY_BITS'(2 * int'(node) + 1 + int'(b));
      end
      return p;
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!hit && mesi_q[set_r][WAY_BITS'(w)] != MESI_I && tag_q[set_r][WAY_BITS'(w)] == tag_r) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
         if (!has_inv && mesi_q[set_r][WAY_BITS'(w)] == MESI_I) begin
            has_inv = 1'b1;
            inv_way = WAY_BITS'(w);
         end
      end
      victim = has_inv ? inv_way : plru_victim(plru_q[set_r]);
   end

   assign hit_state = mesi_q[set_r][hit_way];
   assign vic_state = mesi_q[set_r][victim];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state    = state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      rsp_hit       = 1'b0;
      rsp_way       = '0;
      rsp_mesi      = MESI_I;
      bus_req_valid = 1'b0;
      bus_req_op    = BUS_READ;
      bus_req_addr  = '0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = S_LOOKUP;
         end
         S_LOOKUP: begin
            case (op_r)
               OP_CLEAR: next_state = S_RESP;
               OP_SNOOP: next_state = (hit && hit_state == MESI_M) ? S_WB : S_RESP;
               default: begin
                  if (hit)
                     next_state = (op_r == OP_WRITE && hit_state == MESI_S) ? S_INV : S_RESP;
                  else
                     next_state = (vic_state == MESI_M) ? S_WB : S_FILL;
               end
            endcase
         end
         S_INV: begin
            bus_req_valid = 1'b1;
            bus_req_op    = BUS_INVAL;
            bus_req_addr  = {tag_r, set_r, {OFFSET_BITS{1'b0}}};
            if (bus_req_ready) next_state = S_RESP;
         end
         S_WB: begin
            bus_req_valid = 1'b1;
            bus_req_op    = BUS_WB;
            bus_req_addr  = {wb_tag_r, set_r, {OFFSET_BITS{1'b0}}};
            if (bus_req_ready) next_state = (op_r == OP_SNOOP) ? S_RESP : S_FILL;
         end
         S_FILL: begin
            if (!fill_issued) begin
               bus_req_valid = 1'b1;
               bus_req_op    = (op_r == OP_WRITE) ? BUS_RWITM : BUS_READ;
               bus_req_addr  = {tag_r, set_r, {OFFSET_BITS{1'b0}}};
            end else if (bus_rsp_valid) begin
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid  = 1'b1;
            rsp_hit    = hit_r;
            rsp_way    = way_r;
            rsp_mesi   = mesi_r;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r        <= OP_READ;
         tag_r       <= '0;
         set_r       <= '0;
         way_r       <= '0;
         wb_tag_r    <= '0;
         hit_r       <= 1'b0;
         mesi_r      <= MESI_I;
         fill_issued <= 1'b0;
         tag_q       <= '{default: '0};
         mesi_q      <= '{default: '0};
         plru_q      <= '{default: '0};
         read_cnt    <= '0;
         write_cnt   <= '0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               op_r  <= req_op;
               tag_r <= req_addr[ADDR_W-1 -: TAG_W];
               set_r <= req_addr[OFFSET_BITS +: SET_BITS];
            end
            S_LOOKUP: begin
               fill_issued <= 1'b0;
               case (op_r)
                  OP_CLEAR: begin
                     mesi_q    <= '{default: '0};
                     tag_q     <= '{default: '0};
                     plru_q    <= '{default: '0};
                     read_cnt  <= '0;
                     write_cnt <= '0;
                     hit_cnt   <= '0;
                     miss_cnt  <= '0;
                     hit_r     <= 1'b0;
                     way_r     <= '0;
                     mesi_r    <= MESI_I;
                  end
                  OP_SNOOP: begin
                     hit_r    <= hit;
                     way_r    <= hit ? hit_way : '0;
                     wb_tag_r <= tag_r;
                     mesi_r   <= MESI_I;
                     if (hit && hit_state != MESI_M) mesi_q[set_r][hit_way] <= MESI_I;
                  end
                  default: begin
                     if (op_r == OP_READ) begin
                        if (read_cnt != '1) read_cnt <= read_cnt + COUNTER_BITS'(1);
                     end else begin
                        if (write_cnt != '1) write_cnt <= write_cnt + COUNTER_BITS'(1);
                     end
                     if (hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + COUNTER_BITS'(1);
                     end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + COUNTER_BITS'(1);
                     end
                     hit_r    <= hit;
                     way_r    <= hit ? hit_way : victim;
                     wb_tag_r <= tag_q[set_r][victim];
                     if (hit && op_r == OP_READ) begin
                        mesi_r         <= hit_state;
                        plru_q[set_r]  <= plru_touch(plru_q[set_r], hit_way);
                     end else if (hit && hit_state != MESI_S) begin
                        mesi_r                 <= MESI_M;
                        mesi_q[set_r][hit_way] <= MESI_M;
                        plru_q[set_r]          <= plru_touch(plru_q[set_r], hit_way);
                     end
                  end
               endcase
            end
            S_INV: if (bus_req_ready) begin
               mesi_q[set_r][way_r] <= MESI_M;
               mesi_r               <= MESI_M;
               plru_q[set_r]        <= plru_touch(plru_q[set_r], way_r);
            end
            S_WB: if (bus_req_ready && op_r == OP_SNOOP) mesi_q[set_r][way_r] <= MESI_I;
            S_FILL: begin
               if (!fill_issued) begin
                  if (bus_req_ready) fill_issued <= 1'b1;
               end else if (bus_rsp_valid) begin
                  tag_q[set_r][way_r]  <= tag_r;
                  mesi_q[set_r][way_r] <= (op_r == OP_WRITE) ? MESI_M : (bus_rsp_shared ? MESI_S : MESI_E);
                  mesi_r               <= (op_r == OP_WRITE) ? MESI_M : (bus_rsp_shared ? MESI_S : MESI_E);
                  plru_q[set_r]        <= plru_touch(plru_q[set_r], way_r);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
